// File: rtl/pipe_stage_skid_reg.sv
// Reusable valid/ready pipeline stage with a 2-entry skid buffer and flush.
// Optional perf counters (STALL_CNT, BUBBLE_CNT) via `define STAGE_PERF_CNT_EN.
module pipe_stage_skid_reg #(
   parameter int DATA_W = 32,
   parameter int CTRL_W = 4,
   parameter int CNT_W  = 16
) (
   input  logic              CLK,
   input  logic              RESET,
   input  logic              FLUSH,
   input  logic              IN_VALID,
   output logic              IN_READY,
   input  logic [CTRL_W-1:0] IN_CTRL,
   input  logic [DATA_W-1:0] IN_DATA,
   output logic              OUT_VALID,
   input  logic              OUT_READY,
   output logic [CTRL_W-1:0] OUT_CTRL,
   output logic [DATA_W-1:0] OUT_DATA,
   output logic [1:0]        OCCUPANCY
`ifdef STAGE_PERF_CNT_EN
   ,
   output logic [CNT_W-1:0]  STALL_CNT,
   output logic [CNT_W-1:0]  BUBBLE_CNT
`endif
);

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      FULL  = 2'd2
   } state_e;

   state_e            state_q, state_d;
   logic [CTRL_W-1:0] main_ctrl_q, main_ctrl_d;
   logic [DATA_W-1:0] main_data_q, main_data_d;
   logic [CTRL_W-1:0] skid_ctrl_q, skid_ctrl_d;
   logic [DATA_W-1:0] skid_data_q, skid_data_d;
   logic              in_xfer;
   logic              out_xfer;

   // Ready comes from state flops only, so downstream ready never reaches upstream.
   assign IN_READY  = !RESET && (state_q != FULL);
   assign OUT_VALID = (state_q != EMPTY);
   assign OUT_CTRL  = OUT_VALID ? main_ctrl_q : '0;
   assign OUT_DATA  = main_data_q;
   assign OCCUPANCY = state_q;

   assign in_xfer  = IN_VALID && IN_READY;
   assign out_xfer = OUT_VALID && OUT_READY;

   always_comb begin
      state_d     = state_q;
      main_ctrl_d = main_ctrl_q;
      main_data_d = main_data_q;
      skid_ctrl_d = skid_ctrl_q;
      skid_data_d = skid_data_q;
      if (FLUSH) begin
         state_d     = EMPTY;
         main_ctrl_d = '0;
         skid_ctrl_d = '0;
      end else begin
         unique case (state_q)
            EMPTY: begin
               if (in_xfer) begin
                  main_ctrl_d = IN_CTRL;
                  main_data_d = IN_DATA;
                  state_d     = ONE;
               end
            end
            ONE: begin
               if (in_xfer && out_xfer) begin
                  main_ctrl_d = IN_CTRL;
                  main_data_d = IN_DATA;
               end else if (in_xfer) begin
                  skid_ctrl_d = IN_CTRL;
                  skid_data_d = IN_DATA;
                  state_d     = FULL;
               end else if (out_xfer) begin
                  state_d = EMPTY;
               end
            end
            FULL: begin
               if (out_xfer) begin
                  main_ctrl_d = skid_ctrl_q;
                  main_data_d = skid_data_q;
                  state_d     = ONE;
               end
            end
            default: state_d = EMPTY;
         endcase
      end
   end

   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         state_q     <= EMPTY;
         main_ctrl_q <= '0;
         main_data_q <= '0;
         skid_ctrl_q <= '0;
         skid_data_q <= '0;
      end else begin
         state_q     <= state_d;
         main_ctrl_q <= main_ctrl_d;
         main_data_q <= main_data_d;
         skid_ctrl_q <= skid_ctrl_d;
         skid_data_q <= skid_data_d;
      end
   end

`ifdef STAGE_PERF_CNT_EN
   logic [CNT_W-1:0] stall_q;
   logic [CNT_W-1:0] bubble_q;

   // Saturating; only reset clears them so flushes do not hide history.
   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         stall_q  <= '0;
         bubble_q <= '0;
      end else begin
         if (OUT_VALID && !OUT_READY && (stall_q != '1))
            stall_q <= stall_q + 1'b1;
         if (!OUT_VALID && (bubble_q != '1))
            bubble_q <= bubble_q + 1'b1;
      end
   end

   assign STALL_CNT  = stall_q;
   assign BUBBLE_CNT = bubble_q;
`else
   // Counters absent in this build.
`endif

endmodule

// File: tb/tb_pipe_stage_skid_reg.sv
// Bench for pipe_stage_skid_reg: directed steps plus random traffic
// checked against a queue-based FIFO model.
module tb_pipe_stage_skid_reg;

   logic        CLK = 1'b0;
   logic        RESET = 1'b1;
   logic        FLUSH = 1'b0;
   logic        IN_VALID = 1'b0;
   logic        IN_READY;
   logic [3:0]  IN_CTRL = '0;
   logic [31:0] IN_DATA = '0;
   logic        OUT_VALID;
   logic        OUT_READY = 1'b0;
   logic [3:0]  OUT_CTRL;
   logic [31:0] OUT_DATA;
   logic [1:0]  OCCUPANCY;
`ifdef STAGE_PERF_CNT_EN
   logic [3:0]  STALL_CNT;
   logic [3:0]  BUBBLE_CNT;
`endif

   int errors = 0;
   int checks = 0;

   typedef struct packed {
      logic [3:0]  c;
      logic [31:0] d;
   } ent_t;

   ent_t mq[$];

   pipe_stage_skid_reg #(
      .DATA_W(32),
      .CTRL_W(4),
      .CNT_W (4)
   ) dut (
      .CLK      (CLK),
      .RESET    (RESET),
      .FLUSH    (FLUSH),
      .IN_VALID (IN_VALID),
      .IN_READY (IN_READY),
      .IN_CTRL  (IN_CTRL),
      .IN_DATA  (IN_DATA),
      .OUT_VALID(OUT_VALID),
      .OUT_READY(OUT_READY),
      .OUT_CTRL (OUT_CTRL),
      .OUT_DATA (OUT_DATA),
      .OCCUPANCY(OCCUPANCY)
`ifdef STAGE_PERF_CNT_EN
      ,
      .STALL_CNT (STALL_CNT),
      .BUBBLE_CNT(BUBBLE_CNT)
`endif
   );

   always #5 CLK = ~CLK;

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic check_model();
      int n;
      n = mq.size();
      chk("occupancy", 32'(OCCUPANCY), 32'(n));
      chk("out_valid", 32'(OUT_VALID), 32'(n > 0));
      chk("in_ready", 32'(IN_READY), 32'(n < 2));
      chk("out_ctrl", 32'(OUT_CTRL), (n > 0) ? 32'(mq[0].c) : 32'd0);
      if (n > 0)
         chk("out_data", OUT_DATA, mq[0].d);
   endtask

   // One clock: model consumes the handshakes seen just before the edge.
   task automatic step();
      bit inx;
      bit outx;
      inx  = IN_VALID && (mq.size() < 2);
      outx = OUT_READY && (mq.size() > 0);
      @(posedge CLK);
      #1;
      if (FLUSH) begin
         mq.delete();
      end else begin
         if (outx)
            void'(mq.pop_front());
         if (inx)
            mq.push_back({IN_CTRL, IN_DATA});
      end
      check_model();
   endtask

   task automatic drive(input bit v, input logic [31:0] d,
                        input logic [3:0] c);
      IN_VALID = v;
      IN_DATA  = d;
      IN_CTRL  = c;
   endtask

   initial begin
      // Reset state
      #12;
      chk("rst_valid", 32'(OUT_VALID), 32'd0);
      chk("rst_ready", 32'(IN_READY), 32'd0);
      chk("rst_data", OUT_DATA, 32'd0);
      chk("rst_occ", 32'(OCCUPANCY), 32'd0);
      @(posedge CLK);
      #1;
      RESET = 1'b0;
      #1;
      chk("rel_ready", 32'(IN_READY), 32'd1);

      // Single entry
      OUT_READY = 1'b1;
      drive(1'b1, 32'h10, 4'b0101);
      step();
      chk("first_data", OUT_DATA, 32'h10);
      chk("first_ctrl", 32'(OUT_CTRL), 32'h5);
      chk("first_occ", 32'(OCCUPANCY), 32'd1);

      // Streaming 1..8
      for (int i = 1; i <= 8; i++) begin
         drive(1'b1, 32'(i), 4'(i));
         step();
         chk("stream_data", OUT_DATA, 32'(i));
         chk("stream_ready", 32'(IN_READY), 32'd1);
      end
      drive(1'b0, 32'hdead, 4'hf);
      step();
      step();

      // Backpressure A, B, C
      OUT_READY = 1'b0;
      drive(1'b1, 32'hA, 4'h1);
      step();
      drive(1'b1, 32'hB, 4'h2);
      step();
      drive(1'b1, 32'hC, 4'h3);
      step();
      step();
      chk("bp_occ", 32'(OCCUPANCY), 32'd2);
      chk("bp_ready", 32'(IN_READY), 32'd0);
      chk("bp_hold", OUT_DATA, 32'hA);
      OUT_READY = 1'b1;
      step();
      chk("bp_out_b", OUT_DATA, 32'hB);
      step();
      chk("bp_out_c", OUT_DATA, 32'hC);
      drive(1'b0, 32'h0, 4'h0);
      step();
      chk("bp_drained", 32'(OUT_VALID), 32'd0);

      // Flush while full, same-cycle input dropped
      OUT_READY = 1'b0;
      drive(1'b1, 32'hA, 4'h7);
      step();
      drive(1'b1, 32'hB, 4'h6);
      step();
      drive(1'b1, 32'hC, 4'h5);
      FLUSH = 1'b1;
      step();
      FLUSH = 1'b0;
      drive(1'b0, 32'hC, 4'h5);
      chk("fl_valid", 32'(OUT_VALID), 32'd0);
      chk("fl_ctrl", 32'(OUT_CTRL), 32'd0);
      chk("fl_occ", 32'(OCCUPANCY), 32'd0);
      OUT_READY = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step();
         chk("fl_no_c", 32'(OUT_VALID), 32'd0);
      end

      // Random traffic
      for (int i = 0; i < 400; i++) begin
         drive(1'($urandom_range(0, 1)), $urandom, 4'($urandom));
         OUT_READY = 1'($urandom_range(0, 2) != 0);
         FLUSH = ($urandom_range(0, 19) == 0);
         step();
      end
      FLUSH = 1'b0;

      // Async reset while full
      OUT_READY = 1'b0;
      drive(1'b1, 32'h11, 4'h9);
      step();
      drive(1'b1, 32'h22, 4'ha);
      step();
      drive(1'b0, 32'h0, 4'h0);
      chk("pre_rst_occ", 32'(OCCUPANCY), 32'd2);
      #2;
      RESET = 1'b1;
      #1;
      mq.delete();
      chk("arst_valid", 32'(OUT_VALID), 32'd0);
      chk("arst_ctrl", 32'(OUT_CTRL), 32'd0);
      chk("arst_data", OUT_DATA, 32'd0);
      chk("arst_ready", 32'(IN_READY), 32'd0);
      chk("arst_occ", 32'(OCCUPANCY), 32'd0);
      @(posedge CLK);
      #1;
      RESET = 1'b0;
      #1;
      chk("arel_ready", 32'(IN_READY), 32'd1);
      drive(1'b1, 32'h33, 4'hb);
      step();
      chk("arel_data", OUT_DATA, 32'h33);

`ifdef STAGE_PERF_CNT_EN
      drive(1'b0, 32'h0, 4'h0);
      for (int i = 0; i < 20; i++)
         step();
      chk("stall_sat", 32'(STALL_CNT), 32'd15);
      FLUSH = 1'b1;
      step();
      FLUSH = 1'b0;
      chk("stall_keep", 32'(STALL_CNT), 32'd15);
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/pipe_stage_skid_reg.md
Name: pipe_stage_skid_reg

Overview:
Generic, parametrised pipeline stage register that replaces the fixed per-stage registers (IF/ID, ID/EX, EX/MEM, MEM/WB) with one reusable block.
- Valid/ready handshake on both sides.
- 2-entry skid buffer: full throughput, with no combinational path from downstream ready to upstream ready.
- Synchronous flush for branch/exception squash.
- Control field forced to zero whenever the stage holds a bubble.

Parameters:
DATA_W, 32, width of payload (PC, ALU result, rs2 data, func3, rd address, packed).
CTRL_W, 4, width of control field (reg write en, mem read/write en, WB select); zeroed on bubble or flush.
CNT_W, 16, width of performance counters (used only with the optional feature).

Ports:
CLK  in  1  clock; all state changes on rising edge.
RESET  in  1  asynchronous, active-high reset.
FLUSH  in  1  synchronous squash of all held entries.
IN_VALID  in  1  upstream has an entry.
IN_READY  out  1  stage can accept an entry.
IN_CTRL  in  CTRL_W  upstream control bits.
IN_DATA  in  DATA_W  upstream payload.
OUT_VALID  out  1  stage presents an entry.
OUT_READY  in  1  downstream accepts the entry (e.g. the inverse of MEM_BUSYWAIT).
OUT_CTRL  out  CTRL_W  control bits; 0 when OUT_VALID=0.
OUT_DATA  out  DATA_W  payload from the main slot.
OCCUPANCY  out  2  number of held entries: 0, 1 or 2.

Behaviour:
- Storage:
  - Main slot {ctrl, data} drives the outputs.
  - Skid slot {ctrl, data}.
  - State register EMPTY(0) / ONE(1) / FULL(2); OCCUPANCY = state encoding.
- Handshake definitions:
  - Input transfer: IN_VALID && IN_READY.
  - Output transfer: OUT_VALID && OUT_READY.
- IN_READY is decoded from the state flops only: 1 when state != FULL, forced 0 while RESET=1. It never depends combinationally on OUT_READY.
- OUT_VALID = (state != EMPTY). OUT_CTRL = main ctrl gated by OUT_VALID.
- Transitions (edge of CLK, no flush):
  - EMPTY + input transfer: main <= IN, state -> ONE.
  - ONE + input only: skid <= IN, state -> FULL.
  - ONE + input + output: main <= IN, state stays ONE.
  - ONE + output only: state -> EMPTY.
  - FULL + output: main <= skid, state -> ONE. No input is possible (IN_READY=0).
  - No transfer: all state held. This covers a downstream stall: data is stable while OUT_READY=0.
- Timing:
  - Latency: an entry accepted on edge N is visible on OUT_* after edge N (1 cycle).
  - Sustained throughput: 1 entry/cycle when OUT_READY=1.
- Ordering is strictly FIFO: the skid entry is always younger than the main entry.
- FLUSH=1 at an edge:
  - state -> EMPTY; main and skid ctrl <= 0.
  - Data flops hold their values.
  - Any input transfer in the same cycle is dropped.
  - An output transfer in the same cycle still counts downstream, since the consumer sampled it.
  - FLUSH has priority over every transition.
- Reset (asynchronous, any time including mid-transfer or FULL):
  - state=EMPTY; main/skid ctrl and data = 0.
  - OUT_VALID=0, OUT_CTRL=0, OUT_DATA=0, OCCUPANCY=0, IN_READY=0.
  - After deassertion: IN_READY=1, and the first edge may accept an entry.
- X-safety: IN_CTRL/IN_DATA are ignored when IN_VALID=0. The idle state is never corrupted.

Optional Feature:
Macro STAGE_PERF_CNT_EN.
- Defined: adds output ports STALL_CNT (CNT_W) and BUBBLE_CNT (CNT_W).
  - STALL_CNT increments each cycle with OUT_VALID=1 && OUT_READY=0.
  - BUBBLE_CNT increments each cycle with OUT_VALID=0.
  - Both saturate at 2^CNT_W-1 (no wrap).
  - Cleared by RESET only; FLUSH does not clear them.
- Not defined: ports and counters are absent; all other behaviour is identical.

Test Plan:
- Reset, then IN_VALID=1, IN_DATA=0x00000010, IN_CTRL=4'b0101, OUT_READY=1 for one edge -> next cycle OUT_VALID=1, OUT_DATA=0x10, OUT_CTRL=0101, OCCUPANCY=1.
- Streaming 0x1..0x8 with OUT_READY=1 throughout -> OUT_DATA sequence 0x1..0x8 on consecutive cycles, no gaps, IN_READY stays 1.
- Send 0xA, 0xB, 0xC while OUT_READY=0 -> after 0xA and 0xB OCCUPANCY=2, IN_READY=0, 0xC is held upstream. Raise OUT_READY -> outputs 0xA, 0xB, 0xC in order, with no loss or duplication.
- FULL state (0xA main, 0xB skid), assert FLUSH together with IN_VALID=1 carrying 0xC -> next cycle OUT_VALID=0, OUT_CTRL=0, OCCUPANCY=0; 0xC never appears.
- Assert RESET asynchronously mid-cycle while FULL -> immediately OUT_VALID=0, OUT_CTRL=0, OUT_DATA=0, IN_READY=0; after release IN_READY=1.
- With STAGE_PERF_CNT_EN and CNT_W=4: hold one entry with OUT_READY=0 for 20 cycles -> STALL_CNT saturates at 15. A FLUSH afterwards leaves STALL_CNT=15.
